// File: rtl/simon_pkg.sv
// Shared definitions for the Simon cipher register block: register offsets,
// AXI response codes, control/status bit positions and FSM state types.
package simon_pkg;

    localparam logic [5:0] CTRL_OFS   = 6'h00;
    localparam logic [5:0] STATUS_OFS = 6'h04;
    localparam logic [5:0] KEY_OFS    = 6'h08;
    localparam logic [5:0] DIN_OFS    = 6'h18;
    localparam logic [5:0] DOUT_OFS   = 6'h20;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_DECRYPT_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Byte-lane merge of a write into an existing 32-bit word.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/simon_axi_regs.sv
// AXI4-lite register block for the Simon cipher core: key/input/mode registers,
// start pulse generation, and capture of the core's result and done status.
module simon_axi_regs
    import simon_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int KEY_W      = 128,
    parameter int BLOCK_W    = 64
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  core_start,
    output logic                  core_decrypt,
    output logic [KEY_W-1:0]      core_key,
    output logic [BLOCK_W-1:0]    core_din,
    input  logic                  core_busy,
    input  logic                  core_done,
    input  logic [BLOCK_W-1:0]    core_dout
);

    localparam int KEY_WORDS   = KEY_W / 32;
    localparam int BLOCK_WORDS = BLOCK_W / 32;
    localparam int CTRL_IDX    = int'(CTRL_OFS) / 4;
    localparam int STATUS_IDX  = int'(STATUS_OFS) / 4;
    localparam int KEY_IDX     = int'(KEY_OFS) / 4;
    localparam int DIN_IDX     = int'(DIN_OFS) / 4;
    localparam int DOUT_IDX    = int'(DOUT_OFS) / 4;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic                 decrypt_q, decrypt_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [BLOCK_W-1:0]   din_q, din_d;
    logic [BLOCK_W-1:0]   dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 core_start_q, core_start_d;

    logic                 w_fire, r_fire;
    int                   w_idx, r_idx;
    logic                 w_writable, w_err, start_req;
    logic                 rd_hit;
    logic [31:0]          rd_word;
    logic                 unused_ok;

    assign unused_ok = ^{awprot, arprot, awaddr[ADDR_WIDTH-1:6], awaddr[1:0],
                         araddr[ADDR_WIDTH-1:6], araddr[1:0]};

    assign w_idx  = int'({28'd0, awaddr[5:2]});
    assign r_idx  = int'({28'd0, araddr[5:2]});
    // Address and data are only taken together; a lone channel waits.
    assign w_fire = !arst && (w_state_q == W_IDLE) && awvalid && wvalid;
    assign r_fire = !arst && (r_state_q == R_IDLE) && arvalid;

    // NOTE: every signal written below gets a default first so no latch is inferred.
    always_comb begin
        w_writable = (w_idx == CTRL_IDX)
                  || (w_idx >= KEY_IDX && w_idx < KEY_IDX + KEY_WORDS)
                  || (w_idx >= DIN_IDX && w_idx < DIN_IDX + BLOCK_WORDS);
        w_err      = !w_writable || core_busy;
        w_state_d  = w_state_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        key_d      = key_q;
        din_d      = din_q;
        decrypt_d  = decrypt_q;
        start_req  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_fire) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
                    if (!w_err) begin
                        if (w_idx == CTRL_IDX && wstrb[0]) begin
                            decrypt_d = wdata[CTRL_DECRYPT_BIT];
                            start_req = wdata[CTRL_START_BIT];
                        end
                        for (int i = 0; i < KEY_WORDS; i++) begin
                            if (w_idx == KEY_IDX + i)
                                key_d[32*i +: 32] = apply_wstrb(key_q[32*i +: 32], wdata, wstrb);
                        end
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            if (w_idx == DIN_IDX + i)
                                din_d[32*i +: 32] = apply_wstrb(din_q[32*i +: 32], wdata, wstrb);
                        end
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // A start request outranks a simultaneous core_done for the DONE flag.
    always_comb begin
        core_start_d = start_req;
        done_d       = start_req ? 1'b0 : (core_done ? 1'b1 : done_q);
        dout_d       = core_done ? core_dout : dout_q;
    end

    always_comb begin
        rd_word = 32'd0;
        rd_hit  = 1'b0;
        if (r_idx == CTRL_IDX) begin
            rd_word[CTRL_DECRYPT_BIT] = decrypt_q;
            rd_hit = 1'b1;
        end
        if (r_idx == STATUS_IDX) begin
            rd_word[STATUS_BUSY_BIT] = core_busy;
            rd_word[STATUS_DONE_BIT] = done_q;
            rd_hit = 1'b1;
        end
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (r_idx == KEY_IDX + i) begin
                rd_word = key_q[32*i +: 32];
                rd_hit  = 1'b1;
            end
        end
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (r_idx == DIN_IDX + i) begin
                rd_word = din_q[32*i +: 32];
                rd_hit  = 1'b1;
            end
            if (r_idx == DOUT_IDX + i) begin
                rd_word = dout_q[32*i +: 32];
                rd_hit  = 1'b1;
            end
        end
    end

    // Read data is sampled from the current (pre-update) register values.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (r_fire) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            rresp_q      <= RESP_OKAY;
            decrypt_q    <= 1'b0;
            key_q        <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            decrypt_q    <= decrypt_d;
            key_q        <= key_d;
            din_q        <= din_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
        end
    end

    assign awready      = w_fire;
    assign wready       = w_fire;
    assign arready      = r_fire;
    assign bvalid       = bvalid_q;
    assign bresp        = bresp_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;
    assign core_start   = core_start_q;
    assign core_decrypt = decrypt_q;
    assign core_key     = key_q;
    assign core_din     = din_q;

endmodule
